// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates at tail, accepts out-of-order writebacks,
// retires one ready entry per cycle from head and raises flush on a branch mispredict.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 dec_rdy,
  input  logic [1:0]           dec_type,
  input  logic [4:0]           dec_rd,
  input  logic [31:0]          dec_pred_pc,
  output logic                 dec_full,
  output logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [ROB_WIDTH-1:0] dec_query_j_id,
  input  logic [ROB_WIDTH-1:0] dec_query_k_id,
  output logic                 dec_query_j_ready,
  output logic                 dec_query_k_ready,
  output logic [31:0]          dec_query_j_data,
  output logic [31:0]          dec_query_k_data,
  input  logic                 rs_rdy,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  input  logic                 rs_set_jump_addr,
  input  logic                 lsb_rdy,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_data,
  output logic                 reg_wr_en,
  output logic [4:0]           reg_wr_rd,
  output logic [31:0]          reg_wr_data,
  output logic [ROB_WIDTH-1:0] reg_wr_rob_id,
  output logic                 lsb_commit_en,
  output logic [ROB_WIDTH-1:0] lsb_commit_rob_id,
  output logic                 flush,
  output logic [31:0]          flush_pc
);

  localparam int ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_BRANCH = 2'd1;
  localparam logic [1:0] T_STORE  = 2'd2;

  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;
  logic [ROB_SIZE-1:0]  r_busy;
  logic [ROB_SIZE-1:0]  r_ready;
  logic [ROB_SIZE-1:0]  r_jump;
  logic [1:0]           r_type    [ROB_SIZE];
  logic [4:0]           r_rd      [ROB_SIZE];
  logic [31:0]          r_value   [ROB_SIZE];
  logic [31:0]          r_pred_pc [ROB_SIZE];

  logic w_active;
  logic w_rs_wb;
  logic w_lsb_wb;
  logic w_alloc;
  logic w_commit;
  logic w_mispredict;

  assign dec_full   = (r_count == (ROB_WIDTH+1)'(ROB_SIZE));
  assign dec_rob_id = r_tail;

  // Nothing but the pulse clear happens while stalled or during the flush cycle.
  assign w_active     = rdy_in && !flush;
  assign w_rs_wb      = w_active && rs_rdy && r_busy[rs_rob_id];
  assign w_lsb_wb     = w_active && lsb_rdy && r_busy[lsb_rob_id] &&
                        !(w_rs_wb && (rs_rob_id == lsb_rob_id));
  assign w_alloc      = w_active && dec_rdy && !dec_full;
  assign w_commit     = w_active && (r_count != '0) && r_ready[r_head];
  assign w_mispredict = w_commit && (r_type[r_head] == T_BRANCH) && r_jump[r_head] &&
                        (r_value[r_head] != r_pred_pc[r_head]);

  function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] id);
    if (w_rs_wb && (rs_rob_id == id)) return {1'b1, rs_data};
    else if (w_lsb_wb && (lsb_rob_id == id)) return {1'b1, lsb_data};
    else return {r_ready[id], r_value[id]};
  endfunction

  assign {dec_query_j_ready, dec_query_j_data} = lookup(dec_query_j_id);
  assign {dec_query_k_ready, dec_query_k_data} = lookup(dec_query_k_id);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_busy            <= '0;
      r_ready           <= '0;
      r_jump            <= '0;
      reg_wr_en         <= 1'b0;
      reg_wr_rd         <= 5'd0;
      reg_wr_data       <= 32'd0;
      reg_wr_rob_id     <= '0;
      lsb_commit_en     <= 1'b0;
      lsb_commit_rob_id <= '0;
      flush             <= 1'b0;
      flush_pc          <= 32'd0;
    end else if (rdy_in) begin
      reg_wr_en     <= 1'b0;
      lsb_commit_en <= 1'b0;
      flush         <= 1'b0;
      if (w_mispredict) begin
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
        r_busy   <= '0;
        r_ready  <= '0;
        flush    <= 1'b1;
        flush_pc <= r_value[r_head];
      end else begin
        if (w_rs_wb) begin
          r_ready[rs_rob_id] <= 1'b1;
          r_jump[rs_rob_id]  <= rs_set_jump_addr;
        end
        if (w_lsb_wb) begin
          r_ready[lsb_rob_id] <= 1'b1;
          r_jump[lsb_rob_id]  <= 1'b0;
        end
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + ROB_WIDTH'(1);
          case (r_type[r_head])
            T_REG: begin
              reg_wr_en     <= 1'b1;
              reg_wr_rd     <= r_rd[r_head];
              reg_wr_data   <= r_value[r_head];
              reg_wr_rob_id <= r_head;
            end
            T_STORE: begin
              lsb_commit_en     <= 1'b1;
              lsb_commit_rob_id <= r_head;
            end
            default: begin
            end
          endcase
        end
        // Allocation never targets a committing head: tail==head only when empty or full.
        if (w_alloc) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_jump[r_tail]  <= 1'b0;
          r_tail          <= r_tail + ROB_WIDTH'(1);
        end
        r_count <= r_count + (ROB_WIDTH+1)'(w_alloc) - (ROB_WIDTH+1)'(w_commit);
      end
    end else begin
      reg_wr_en     <= 1'b0;
      lsb_commit_en <= 1'b0;
      flush         <= 1'b0;
    end
  end

  // Payload storage needs no reset; validity is tracked by r_busy/r_ready.
  always_ff @(posedge clk_in) begin
    if (w_alloc) begin
      r_type[r_tail]    <= (dec_type == 2'd3) ? T_REG : dec_type;
      r_rd[r_tail]      <= (dec_type == 2'd3) ? 5'd0 : dec_rd;
      r_pred_pc[r_tail] <= dec_pred_pc;
    end
    if (w_rs_wb) begin
      r_value[rs_rob_id] <= rs_data;
    end
    if (w_lsb_wb) begin
      r_value[lsb_rob_id] <= lsb_data;
    end
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 3, log2 of entry count; ROB_SIZE = 2**ROB_WIDTH.
REQ-002 SHALL have the ports below, one clock domain; reset is asynchronous and active-high.
  clk_in  input  1  clock, all state on rising edge
  rst_in  input  1  asynchronous active-high reset
  rdy_in  input  1  global enable; low = hold
  dec_rdy  input  1  allocate one entry this cycle
  dec_type  input  2  0 REG (writes rd), 1 BRANCH, 2 STORE; 3 treated as REG with rd=0
  dec_rd  input  5  destination register
  dec_pred_pc  input  32  predicted next PC (BRANCH only)
  dec_full  output  1  no free entry
  dec_rob_id  output  ROB_WIDTH  id the next allocation receives (tail)
  dec_query_j_id, dec_query_k_id  input  ROB_WIDTH  operand lookups
  dec_query_j_ready, dec_query_k_ready  output  1  entry value available
  dec_query_j_data, dec_query_k_data  output  32  entry value
  rs_rdy, rs_rob_id[ROB_WIDTH], rs_data[32], rs_set_jump_addr[1]  input  ALU writeback
  lsb_rdy, lsb_rob_id[ROB_WIDTH], lsb_data[32]  input  load/store writeback
  reg_wr_en  output  1  commit pulse to register file
  reg_wr_rd  output  5; reg_wr_data  output  32; reg_wr_rob_id  output  ROB_WIDTH
  lsb_commit_en  output  1  store at head committed; lsb_commit_rob_id  output  ROB_WIDTH
  flush  output  1  mispredict pulse to all stages
  flush_pc  output  32  redirect PC

Function
REQ-003 SHALL be a circular buffer: head, tail (ROB_WIDTH, wrap modulo ROB_SIZE), count (ROB_WIDTH+1); per entry: busy, ready, type, rd, value, pred_pc, jump flag.
REQ-004 dec_full SHALL equal (count == ROB_SIZE), combinational; dec_rob_id SHALL equal tail.
REQ-005 On edge with rdy_in=1, flush=0, dec_rdy=1: entry[tail] busy=1, ready=0, jump=0, fields loaded; tail+1. dec_rdy while dec_full is a protocol violation; ignored.
REQ-006 Writeback: rs_rdy sets entry[rs_rob_id] value=rs_data, ready=1, jump=rs_set_jump_addr; lsb_rdy likewise with jump=0; both in one cycle to distinct ids SHALL both apply; same id: rs wins. Writebacks to non-busy entries ignored.
REQ-007 Query ready SHALL be 1 if the entry is ready, or an rs/lsb writeback to that id is valid this cycle (bypass, rs priority); data follows the same selection.
REQ-008 Commit: at most one per edge; if count>0 and entry[head].ready, head is popped (busy=0, head+1).
REQ-009 Committed REG: next cycle reg_wr_en=1 for one cycle with rd, value, rob id (rd=0 still reported; regfile discards).
REQ-010 Committed STORE: next cycle lsb_commit_en=1 one cycle with rob id.
REQ-011 Committed BRANCH with jump=1 and value != pred_pc: mispredict; otherwise no output.
REQ-012 Mispredict: at that edge all entries busy=0, head=tail=count=0; next cycle flush=1, flush_pc=value for exactly one cycle.
REQ-013 While flush=1: dec_rdy, rs_rdy, lsb_rdy ignored; no commit.
REQ-014 Simultaneous allocate and commit: count unchanged; dec_full evaluated on pre-edge count (full stays full that cycle).
REQ-015 Commit latency: writeback at edge N, pop at edge N+1 if at head, pulse visible cycle after N+1.
REQ-016 rdy_in=0: no state change; reg_wr_en, lsb_commit_en, flush cleared to 0 at that edge.

Reset
REQ-017 rst_in=1 SHALL immediately (no clock) clear head, tail, count, all busy/ready bits, reg_wr_en, lsb_commit_en, flush, and zero reg_wr_rd, reg_wr_data, reg_wr_rob_id, lsb_commit_rob_id, flush_pc; after reset dec_full=0, dec_rob_id=0.
REQ-018 Reset asserted mid-commit or mid-flush SHALL drop the pending pulse.

Verification
REQ-019 Allocate REG rd=5 (id0), rs writeback id0 data 0x2A -> next cycle pop, following cycle reg_wr_en=1, rd=5, data=0x2A, rob_id=0.
REQ-020 Allocate 8 entries, no writebacks -> dec_full=1, dec_rob_id=0 (wrapped); writeback id0 -> after commit dec_full=0.
REQ-021 Ids 0,1 allocated; writeback id1 before id0 -> no commit until id0 ready; then commits id0 and id1 on consecutive cycles, in order.
REQ-022 BRANCH pred_pc 0x100, rs writeback data 0x200 jump=1 at head -> flush=1, flush_pc=0x200 one cycle; count=0, dec_rob_id=0; writeback in flush cycle ignored.
REQ-023 Query id3 while rs_rdy with rob_id 3, data 0x7 -> query ready=1, data=0x7 same cycle; simultaneous lsb writeback id3 data 0x9 -> rs value retained.
REQ-024 Assert rst_in asynchronously between edges with entries pending -> all outputs zero before next clock; rdy_in=0 for 3 cycles mid-stream -> no commit, state resumes unchanged.
